// File: rtl/mode_seq_pkg.sv
// Shared encodings for the mode_params demo sequencer.
package mode_seq_pkg;

  // FSM state encodings, also exported on the debug state port.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StLoad  = 2'd1,
    StReady = 2'd2,
    StRun   = 2'd3
  } state_e;

  // Which byte of an entry the next config beat carries.
  typedef enum logic {
    PhParams = 1'b0,
    PhHold   = 1'b1
  } phase_e;

  // Controller pattern-mode codes (mode_params bits 6:4).
  localparam logic [2:0] ModePass = 3'd0;
  localparam logic [2:0] ModeRamp = 3'd1;
  localparam logic [2:0] ModeBars = 3'd2;
  localparam logic [2:0] ModeXor1 = 3'd4;
  localparam logic [2:0] ModeXor2 = 3'd5;
  localparam logic [2:0] ModeXor3 = 3'd6;

  // Pack a controller params byte from its fields.
  function automatic logic [7:0] make_params(input logic       timing,
                                             input logic [2:0] pattern,
                                             input logic [3:0] opts);
    return {timing, pattern, opts};
  endfunction

endpackage

// File: rtl/seq_playlist_ram.sv
// Playlist storage: DEPTH entries of {params, hold}, byte-select write, async read.
module seq_playlist_ram
  import mode_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  phase_e        wsel,
  input  logic [7:0]    wdata,
  input  logic [IW-1:0] raddr,
  output logic [7:0]    rparams,
  output logic [7:0]    rhold
);

  // Upper byte holds params, lower byte holds the hold count.
  logic [15:0] mem [DEPTH];

  // Byte-select write; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wsel == PhParams) begin
        mem[waddr][15:8] <= wdata;
      end else begin
        mem[waddr][7:0] <= wdata;
      end
    end
  end

  assign rparams = mem[raddr][15:8];
  assign rhold   = mem[raddr][7:0];

endmodule

// File: rtl/mode_sequencer.sv
// Demo scheduler: loads a playlist over a byte stream and steps mode_params on frame ticks.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter logic [7:0]  DEFAULT_PARAMS = 8'h10,
  localparam int unsigned IW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          run,
  input  logic          cfg_valid,
  input  logic [7:0]    cfg_data,
  input  logic          cfg_last,
  output logic          cfg_ready,
  output logic [7:0]    mode_params,
  output logic [IW-1:0] entry,
  output logic          switch_pulse,
  output logic [1:0]    state
);

  // count ranges 0..DEPTH, so it needs one bit more than the index.
  localparam int unsigned CntW      = IW + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      frames_q, frames_d;
  logic            pending_q, pending_d;
  logic [7:0]      params_q, params_d;
  logic [IW-1:0]   entry_q, entry_d;
  logic            switch_q, switch_d;

  logic            accept;
  logic            we;
  logic [IW-1:0]   waddr;
  phase_e          wsel;
  logic [IW-1:0]   next_idx;
  logic [IW-1:0]   rd_idx;
  logic [7:0]      rd_params;
  logic [7:0]      rd_hold;

  seq_playlist_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wsel   (wsel),
    .wdata  (cfg_data),
    .raddr  (rd_idx),
    .rparams(rd_params),
    .rhold  (rd_hold)
  );

  // Config handshake: open while loading, or while parked in READY with run low.
  always_comb begin
    cfg_ready = 1'b0;
    unique case (state_q)
      StEmpty, StLoad: cfg_ready = 1'b1;
      StReady:         cfg_ready = ~run;
      default:         cfg_ready = 1'b0;
    endcase
  end

  assign accept = cfg_valid & cfg_ready;

  // Wrapping successor index; the read port looks ahead to the entry about to be applied.
  always_comb begin
    next_idx = (({1'b0, idx_q} + CntW'(1)) == count_q) ? '0 : idx_q + IW'(1);
    rd_idx   = pending_q ? '0 : next_idx;
  end

  // Next-state logic for loading, pausing and frame stepping.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    count_d   = count_q;
    idx_d     = idx_q;
    frames_d  = frames_q;
    pending_d = pending_q;
    params_d  = params_q;
    entry_d   = entry_q;
    switch_d  = 1'b0;
    we        = 1'b0;
    waddr     = count_q[IW-1:0];
    wsel      = PhParams;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          we      = 1'b1;
          waddr   = '0;
          count_d = '0;
          phase_d = PhHold;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          we = 1'b1;
          if (phase_q == PhParams) begin
            wsel    = PhParams;
            phase_d = PhHold;
          end else begin
            wsel    = PhHold;
            count_d = count_q + CntW'(1);
            phase_d = PhParams;
            if (cfg_last || (count_q == LastCnt)) begin
              state_d   = StReady;
              pending_d = 1'b1;
              idx_d     = '0;
            end
          end
        end
      end
      StReady: begin
        if (run) begin
          state_d = StRun;
        end else if (accept) begin
          // A new beat here discards the old list and starts over at entry 0.
          we      = 1'b1;
          waddr   = '0;
          wsel    = PhParams;
          count_d = '0;
          phase_d = PhHold;
          state_d = StLoad;
        end
      end
      StRun: begin
        if (!run) begin
          // Pause beats a coincident tick; idx/frames/pending kept for exact resume.
          state_d = StReady;
        end else if (frame_tick) begin
          if (pending_q || (frames_q == 8'd0)) begin
            idx_d     = rd_idx;
            entry_d   = rd_idx;
            params_d  = rd_params;
            frames_d  = rd_hold;
            pending_d = 1'b0;
            switch_d  = 1'b1;
          end else begin
            frames_d = frames_q - 8'd1;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      phase_q   <= PhParams;
      count_q   <= '0;
      idx_q     <= '0;
      frames_q  <= 8'd0;
      pending_q <= 1'b0;
      params_q  <= DEFAULT_PARAMS;
      entry_q   <= '0;
      switch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      frames_q  <= frames_d;
      pending_q <= pending_d;
      params_q  <= params_d;
      entry_q   <= entry_d;
      switch_q  <= switch_d;
    end
  end

  assign mode_params  = params_q;
  assign entry        = entry_q;
  assign switch_pulse = switch_q;
  assign state        = state_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed self-checking bench for mode_sequencer.
module tb_mode_sequencer;
  import mode_seq_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic          run;
  logic          cfg_valid;
  logic [7:0]    cfg_data;
  logic          cfg_last;
  logic          cfg_ready;
  logic [7:0]    mode_params;
  logic [IW-1:0] entry;
  logic          switch_pulse;
  logic [1:0]    state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mode_sequencer #(
    .DEPTH         (DEPTH),
    .DEFAULT_PARAMS(8'h10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .run         (run),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_last    (cfg_last),
    .cfg_ready   (cfg_ready),
    .mode_params (mode_params),
    .entry       (entry),
    .switch_pulse(switch_pulse),
    .state       (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic load_entry(input logic [7:0] p, input logic [7:0] h, input logic last);
    beat(p, 1'b0);
    beat(h, last);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (state !== 2'd0 || mode_params !== 8'h10 || entry !== 3'd0 || switch_pulse !== 1'b0 ||
        cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: state=%0d mp=%h entry=%0d sp=%b rdy=%b want 0/10/0/0/1",
               state, mode_params, entry, switch_pulse, cfg_ready);
    end
  endtask

  task automatic test_load3();
    load_entry(8'h10, 8'd0, 1'b0);
    n_cmp++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL load_mid_state: got %0d want 1", state);
    end
    load_entry(8'h42, 8'd2, 1'b0);
    load_entry(8'h60, 8'd1, 1'b1);
    n_cmp++;
    if (state !== 2'd2 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load3_ready: state=%0d rdy=%b want 2/1", state, cfg_ready);
    end
    run = 1'b1;
    step();
    n_cmp++;
    if (state !== 2'd3 || mode_params !== 8'h10 || entry !== 3'd0 || switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL run_no_tick: state=%0d mp=%h entry=%0d sp=%b want 3/10/0/0",
               state, mode_params, entry, switch_pulse);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_mp [10] = '{8'h10, 8'h42, 8'h42, 8'h42, 8'h60,
                                8'h60, 8'h10, 8'h42, 8'h42, 8'h42};
    logic       exp_sp [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_en [10] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd1, 3'd1, 3'd1};
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      n_cmp++;
      if (mode_params !== exp_mp[i] || switch_pulse !== exp_sp[i] || entry !== exp_en[i]) begin
        n_fail++;
        $display("FAIL seq_tick%0d: mp=%h sp=%b entry=%0d want %h/%b/%0d", i, mode_params,
                 switch_pulse, entry, exp_mp[i], exp_sp[i], exp_en[i]);
      end
      step();
      n_cmp++;
      if (switch_pulse !== 1'b0 || mode_params !== exp_mp[i]) begin
        n_fail++;
        $display("FAIL seq_after%0d: sp=%b mp=%h want 0/%h", i, switch_pulse, mode_params,
                 exp_mp[i]);
      end
    end
  endtask

  task automatic test_full_list();
    run = 1'b0;
    step();
    n_cmp++;
    if (state !== 2'd2 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_ready: state=%0d rdy=%b want 2/1", state, cfg_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      load_entry(8'h20 + 8'(i), 8'd0, 1'b0);
      if (i == DEPTH - 2) begin
        n_cmp++;
        if (state !== 2'd1) begin
          n_fail++;
          $display("FAIL full_before_last: state=%0d want 1", state);
        end
      end
    end
    n_cmp++;
    if (state !== 2'd2 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_auto_ready: state=%0d rdy=%b want 2/1", state, cfg_ready);
    end
    run       = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_run_drop: rdy=%b want 0", cfg_ready);
    end
    step();
    n_cmp++;
    if (state !== 2'd3 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_run: state=%0d rdy=%b want 3/0", state, cfg_ready);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      pulse_tick();
      n_cmp++;
      if (mode_params !== 8'h20 + 8'(i % DEPTH) || entry !== 3'(i % DEPTH) ||
          switch_pulse !== 1'b1) begin
        n_fail++;
        $display("FAIL full_tick%0d: mp=%h entry=%0d sp=%b want %h/%0d/1", i, mode_params,
                 entry, switch_pulse, 8'h20 + 8'(i % DEPTH), i % DEPTH);
      end
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_pause_resume();
    run = 1'b0;
    step();
    load_entry(8'h11, 8'd0, 1'b0);
    load_entry(8'h42, 8'd2, 1'b0);
    load_entry(8'h60, 8'd0, 1'b1);
    run = 1'b1;
    step();
    pulse_tick();
    step();
    pulse_tick();
    step();
    pulse_tick();
    step();
    // Pause and tick in the same cycle: tick must be dropped.
    run        = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n_cmp++;
    if (state !== 2'd2 || mode_params !== 8'h42 || entry !== 3'd1 || switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_tick: state=%0d mp=%h entry=%0d sp=%b want 2/42/1/0",
               state, mode_params, entry, switch_pulse);
    end
    pulse_tick();
    n_cmp++;
    if (mode_params !== 8'h42 || switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL paused_tick: mp=%h sp=%b want 42/0", mode_params, switch_pulse);
    end
    run = 1'b1;
    step();
    pulse_tick();
    n_cmp++;
    if (mode_params !== 8'h42 || switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_last_frame: mp=%h sp=%b want 42/0", mode_params, switch_pulse);
    end
    step();
    pulse_tick();
    n_cmp++;
    if (mode_params !== 8'h60 || switch_pulse !== 1'b1 || entry !== 3'd2) begin
      n_fail++;
      $display("FAIL resume_advance: mp=%h sp=%b entry=%0d want 60/1/2",
               mode_params, switch_pulse, entry);
    end
    step();
    pulse_tick();
    n_cmp++;
    if (mode_params !== 8'h11 || switch_pulse !== 1'b1 || entry !== 3'd0) begin
      n_fail++;
      $display("FAIL resume_wrap: mp=%h sp=%b entry=%0d want 11/1/0",
               mode_params, switch_pulse, entry);
    end
    step();
  endtask

  task automatic test_reset_mid_load();
    run = 1'b0;
    load_entry(8'h42, 8'd1, 1'b0);
    beat(8'h55, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || mode_params !== 8'h10 || entry !== 3'd0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_load: state=%0d mp=%h entry=%0d rdy=%b want 0/10/0/1",
               state, mode_params, entry, cfg_ready);
    end
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      n_cmp++;
      if (switch_pulse !== 1'b0 || state !== 2'd0 || mode_params !== 8'h10) begin
        n_fail++;
        $display("FAIL empty_tick%0d: sp=%b state=%0d mp=%h want 0/0/10", i, switch_pulse,
                 state, mode_params);
      end
      step();
    end
  endtask

  task automatic test_single_entry();
    run = 1'b0;
    load_entry(8'h53, 8'd0, 1'b1);
    n_cmp++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL single_ready: state=%0d want 2", state);
    end
    run = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      n_cmp++;
      if (mode_params !== 8'h53 || switch_pulse !== 1'b1 || entry !== 3'd0) begin
        n_fail++;
        $display("FAIL single_tick%0d: mp=%h sp=%b entry=%0d want 53/1/0", i, mode_params,
                 switch_pulse, entry);
      end
      step();
      n_cmp++;
      if (switch_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL single_after%0d: sp=%b want 0", i, switch_pulse);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    run        = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = 8'h00;
    cfg_last   = 1'b0;
    test_reset();
    test_load3();
    test_sequence();
    test_full_list();
    test_pause_resume();
    test_reset_mid_load();
    test_single_entry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
